// File: rtl/h2u_pattern_checker_pkg.sv
// Shared definitions for the hard-drive-to-user pattern checker: read FSM
// encoding and the default incrementing-pattern constants.
package h2u_pattern_checker_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StActivate = 2'd1,
        StRead     = 2'd2,
        StRelease  = 2'd3
    } rd_state_e;

    localparam logic [31:0] PatternStartDefault = 32'h0000_0000;
    localparam logic [31:0] PatternStepDefault  = 32'h0000_0001;
    localparam int unsigned SizeW               = 24;

endpackage

// File: rtl/h2u_pattern_checker_ppfifo_read_ctrl.sv
// Ping-pong FIFO read-side handshake: claims a full block, strobes every word
// of it back-to-back (first-word-fall-through), then hands the block back.
module h2u_pattern_checker_ppfifo_read_ctrl
    import h2u_pattern_checker_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ready,
    input  logic [SizeW-1:0] size,
    output logic             activate,
    output logic             strobe,
    output logic             busy
);

    rd_state_e        r_state;
    rd_state_e        w_state_next;
    logic [SizeW-1:0] r_blk_size;
    logic [SizeW-1:0] r_word_idx;
    logic             r_busy;
    logic             w_more;
    logic             w_last;

    assign w_more = (r_word_idx < r_blk_size);
    assign w_last = (r_word_idx == (r_blk_size - SizeW'(1)));
    assign busy   = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_blk_size <= '0;
            r_word_idx <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != StIdle);
            if (r_state == StActivate) begin
                r_blk_size <= size;
                r_word_idx <= '0;
            end else if (strobe) begin
                r_word_idx <= r_word_idx + SizeW'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        activate     = 1'b0;
        strobe       = 1'b0;
        unique case (r_state)
            StIdle: begin
                // activate is always low here, so no self-reference is needed
                if (enable && ready) begin
                    w_state_next = StActivate;
                end
            end
            StActivate: begin
                activate     = 1'b1;
                w_state_next = (size == '0) ? StRelease : StRead;
            end
            StRead: begin
                activate = 1'b1;
                strobe   = w_more;
                if (!w_more || w_last) begin
                    w_state_next = StRelease;
                end
            end
            StRelease: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

endmodule

// File: rtl/h2u_pattern_checker.sv
// Drains user data-out FIFO blocks and compares each word against the
// incrementing pattern, keeping totals, an error count and a first-error snapshot.
module h2u_pattern_checker
    import h2u_pattern_checker_pkg::*;
#(
    parameter logic [31:0] PATTERN_START = PatternStartDefault,
    parameter logic [31:0] PATTERN_STEP  = PatternStepDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             restart,
    input  logic             ready,
    output logic             activate,
    input  logic [SizeW-1:0] size,
    input  logic [31:0]      data,
    output logic             strobe,
    output logic             busy,
    output logic             error,
    output logic [15:0]      error_count,
    output logic [SizeW-1:0] total_count,
    output logic [SizeW-1:0] first_err_index,
    output logic [31:0]      first_err_expected,
    output logic [31:0]      first_err_actual
);

    logic             w_strobe;
    logic [31:0]      r_exp;
    logic [31:0]      w_exp_cur;
    logic [SizeW-1:0] w_total_base;
    logic [15:0]      w_err_cnt_base;
    logic             w_error_base;
    logic             w_mismatch;

    h2u_pattern_checker_ppfifo_read_ctrl u_read_ctrl (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .ready    (ready),
        .size     (size),
        .activate (activate),
        .strobe   (w_strobe),
        .busy     (busy)
    );

    assign strobe = w_strobe;

    // A restart coinciding with a strobe makes that word the first of the new run
    assign w_exp_cur      = restart ? PATTERN_START : r_exp;
    assign w_total_base   = restart ? '0 : total_count;
    assign w_err_cnt_base = restart ? '0 : error_count;
    assign w_error_base   = restart ? 1'b0 : error;
    assign w_mismatch     = w_strobe && (data != w_exp_cur);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp              <= PATTERN_START;
            total_count        <= '0;
            error_count        <= '0;
            error              <= 1'b0;
            first_err_index    <= '0;
            first_err_expected <= '0;
            first_err_actual   <= '0;
        end else begin
            if (restart) begin
                r_exp              <= PATTERN_START;
                total_count        <= '0;
                error_count        <= '0;
                error              <= 1'b0;
                first_err_index    <= '0;
                first_err_expected <= '0;
                first_err_actual   <= '0;
            end
            if (w_strobe) begin
                r_exp       <= w_exp_cur + PATTERN_STEP;
                total_count <= w_total_base + SizeW'(1);
            end
            if (w_mismatch) begin
                if (w_err_cnt_base != 16'hFFFF) begin
                    error_count <= w_err_cnt_base + 16'd1;
                end
                if (!w_error_base) begin
                    error              <= 1'b1;
                    first_err_index    <= w_total_base;
                    first_err_expected <= w_exp_cur;
                    first_err_actual   <= data;
                end
            end
        end
    end

endmodule

// File: tb/tb_h2u_pattern_checker.sv
// Directed bench for h2u_pattern_checker: a FWFT FIFO model serves blocks of
// the incrementing pattern with optional corruption and mid-block events.
module tb_h2u_pattern_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        restart;
    logic        ready;
    logic        activate;
    logic [23:0] size;
    logic [31:0] data;
    logic        strobe;
    logic        busy;
    logic        error;
    logic [15:0] error_count;
    logic [23:0] total_count;
    logic [23:0] first_err_index;
    logic [31:0] first_err_expected;
    logic [31:0] first_err_actual;

    int n_checks = 0;
    int n_pass   = 0;

    int ptr            = 0;
    int bad_idx        = -1;
    int enable_drop_at = -1;
    int restart_at     = -1;
    int rst_at         = -1;
    bit rst_hit        = 1'b0;

    int strobes;
    int acycles;
    bit contig;
    int act_seen;

    always #5 clk = ~clk;

    assign data = (ptr == bad_idx) ? 32'hDEAD_BEEF : 32'(ptr);

    h2u_pattern_checker dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .restart            (restart),
        .ready              (ready),
        .activate           (activate),
        .size               (size),
        .data               (data),
        .strobe             (strobe),
        .busy               (busy),
        .error              (error),
        .error_count        (error_count),
        .total_count        (total_count),
        .first_err_index    (first_err_index),
        .first_err_expected (first_err_expected),
        .first_err_actual   (first_err_actual)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic pulse_restart();
        @(posedge clk); #1;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    // Offers one block of n words and serves it until activate drops
    task automatic run_block(input int n, output int n_strobe, output int n_act,
                             output bit is_contig);
        int  first_c;
        int  last_c;
        int  c;
        bit  got;
        logic s;
        n_strobe = 0;
        n_act    = 0;
        first_c  = -1;
        last_c   = -1;
        got      = 1'b0;
        rst_hit  = 1'b0;
        size     = 24'(n);
        ready    = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            got = activate;
        end
        ready = 1'b0;
        check("activate_seen", {31'b0, got}, 32'd1);
        c = 0;
        while (got && activate && c < n + 8) begin
            n_act++;
            s = strobe;
            if (s) begin
                n_strobe++;
                if (first_c < 0) first_c = c;
                last_c = c;
                if (ptr == enable_drop_at) enable = 1'b0;
                if (ptr == restart_at) restart = 1'b1;
                if (ptr == rst_at) begin
                    rst = 1'b1;
                    #1;
                    rst_hit = 1'b1;
                    break;
                end
            end
            @(posedge clk); #1;
            restart = 1'b0;
            if (s) ptr++;
            c++;
        end
        check("block_done", {31'b0, activate}, 32'd0);
        is_contig = (n_strobe == 0) || (last_c - first_c + 1 == n_strobe);
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        restart = 1'b0;
        ready   = 1'b0;
        size    = '0;
        #2;
        check("rst_activate", {31'b0, activate}, 32'd0);
        check("rst_strobe", {31'b0, strobe}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_err_cnt", {16'b0, error_count}, 32'd0);
        check("rst_total", {8'b0, total_count}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Clean run: two 512-word blocks carrying 0..1023
        ptr = 0;
        for (int b = 0; b < 2; b++) begin
            run_block(512, strobes, acycles, contig);
            check("clean_strobes", strobes, 512);
            check("clean_contig", {31'b0, contig}, 32'd1);
            check("clean_act_cycles", acycles, 513);
        end
        @(posedge clk); #1;
        check("clean_total", {8'b0, total_count}, 32'd1024);
        check("clean_error", {31'b0, error}, 32'd0);
        check("clean_err_cnt", {16'b0, error_count}, 32'd0);
        check("clean_busy_idle", {31'b0, busy}, 32'd0);

        // Single corruption at word 300
        pulse_restart();
        check("restart_total", {8'b0, total_count}, 32'd0);
        ptr     = 0;
        bad_idx = 300;
        run_block(512, strobes, acycles, contig);
        bad_idx = -1;
        check("bad_strobes", strobes, 512);
        check("bad_error", {31'b0, error}, 32'd1);
        check("bad_err_cnt", {16'b0, error_count}, 32'd1);
        check("bad_index", {8'b0, first_err_index}, 32'd300);
        check("bad_expected", first_err_expected, 32'd300);
        check("bad_actual", first_err_actual, 32'hDEAD_BEEF);
        check("bad_total", {8'b0, total_count}, 32'd512);

        // Zero-size block
        run_block(0, strobes, acycles, contig);
        check("zero_act_cycles", acycles, 1);
        check("zero_strobes", strobes, 0);
        @(posedge clk); #1;
        check("zero_total", {8'b0, total_count}, 32'd512);
        check("zero_err_cnt", {16'b0, error_count}, 32'd1);

        // enable dropped at word 10 of a 64-word block
        pulse_restart();
        ptr            = 0;
        enable_drop_at = 10;
        run_block(64, strobes, acycles, contig);
        enable_drop_at = -1;
        check("endrop_strobes", strobes, 64);
        check("endrop_contig", {31'b0, contig}, 32'd1);
        ready    = 1'b1;
        act_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (activate || busy) act_seen++;
        end
        ready = 1'b0;
        check("endrop_stays_idle", act_seen, 0);
        check("endrop_total", {8'b0, total_count}, 32'd64);
        check("endrop_error", {31'b0, error}, 32'd0);
        enable = 1'b1;

        // restart pulsed at word 20 of a 40-word block
        pulse_restart();
        ptr        = 0;
        restart_at = 20;
        run_block(40, strobes, acycles, contig);
        restart_at = -1;
        check("rstrt_strobes", strobes, 40);
        check("rstrt_total", {8'b0, total_count}, 32'd20);
        check("rstrt_err_cnt", {16'b0, error_count}, 32'd20);
        check("rstrt_index", {8'b0, first_err_index}, 32'd0);
        check("rstrt_expected", first_err_expected, 32'd0);
        check("rstrt_actual", first_err_actual, 32'd20);

        // Async reset mid-READ
        ptr    = 0;
        rst_at = 15;
        run_block(32, strobes, acycles, contig);
        rst_at = -1;
        check("arst_hit", {31'b0, rst_hit}, 32'd1);
        check("arst_activate", {31'b0, activate}, 32'd0);
        check("arst_strobe", {31'b0, strobe}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_total", {8'b0, total_count}, 32'd0);
        check("arst_err_cnt", {16'b0, error_count}, 32'd0);
        check("arst_actual", first_err_actual, 32'd0);
        #2;
        rst = 1'b0;
        ptr = 0;
        run_block(8, strobes, acycles, contig);
        @(posedge clk); #1;
        check("post_rst_total", {8'b0, total_count}, 32'd8);
        check("post_rst_error", {31'b0, error}, 32'd0);
        check("post_rst_err_cnt", {16'b0, error_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/h2u_pattern_checker.md
# h2u_pattern_checker

Read-side consumer of the user data-out ping-pong FIFO (hard drive → user) in the SATA simulation bench. It drains every block the stack presents and compares each word against the incrementing pattern the faux hard drive transmits. It reports word totals, a saturating error count and a snapshot of the first mismatch. It is the checking counterpart to the bench's data generator.

## Interface
Parameters:
- PATTERN_START, 32'h00000000, first expected word after a pattern restart
- PATTERN_STEP, 32'h00000001, increment added per word, modulo 2^32

Ports:
- clk, in, 1, bench clock
- rst, in, 1, reset; asynchronous, active-high
- enable, in, 1, permit new FIFO blocks to be taken
- restart, in, 1, single-cycle pulse; clears counters, error capture and expected pattern
- ready, in, 1, FIFO read side has a full block available
- activate, out, 1, block owned by this reader
- size, in, 24, word count of the presented block, sampled at activation
- data, in, 32, current FIFO word, valid while activate is high
- strobe, out, 1, pops the current word
- busy, out, 1, FSM not IDLE
- error, out, 1, sticky; set on the first mismatch
- error_count, out, 16, mismatches, saturating at 16'hFFFF
- total_count, out, 24, words consumed, wraps modulo 2^24
- first_err_index, out, 24, total_count value of the first bad word
- first_err_expected, out, 32, expected value at the first mismatch
- first_err_actual, out, 32, received value at the first mismatch

## Operation
- FSM states: IDLE, ACTIVATE, READ, RELEASE.
- IDLE → ACTIVATE: when enable && ready && !activate.
- ACTIVATE: drive activate=1, latch size into blk_size, clear word_idx.
  - blk_size==0 → RELEASE.
  - Otherwise → READ.
- READ: the FIFO is first-word-fall-through. Each cycle, while word_idx<blk_size:
  - strobe=1.
  - Compare data against exp.
  - exp += PATTERN_STEP; word_idx++; total_count++.
  - On the cycle the last word is strobed, go to RELEASE.
- RELEASE: activate=0, strobe=0, then → IDLE.
- Mismatch (data != exp while strobing):
  - error_count++ (saturating).
  - If error==0: set error and load all three first_err_* registers in the same cycle.
- enable falling mid-block does not abort: the current block completes and the FSM then stays in IDLE.
- restart:
  - exp ← PATTERN_START; total_count, error_count and error ← 0; first_err_* ← 0.
  - If it arrives mid-block, the FSM keeps draining the block. The strobe in that same cycle compares against PATTERN_START, and counting restarts from that word.
- Reset values:
  - activate, strobe, busy, error = 0.
  - All counters and captures = 0.
  - exp = PATTERN_START; state = IDLE.
- Reset mid-block drops activate asynchronously; block recovery is the FIFO's responsibility.

## Timing
- ready sampled high in IDLE → activate high on the next edge.
- First strobe one cycle after activate rises. A block of N words holds strobe high for exactly N consecutive cycles, with no gaps.
- activate falls one cycle after the last strobe. A new activation is possible one cycle after that (ready must be resampled).
- A 1-word block takes 4 cycles IDLE→IDLE; a 0-word block takes 3 cycles.
- error, error_count, total_count and first_err_* update on the edge after the offending strobe cycle (registered, 1-cycle latency).
- busy equals (state != IDLE), registered.

## Structure
- FSM state encodings and PATTERN_* defaults live in the shared simulation defines include next to the existing sata defines, so the generator and the checker share the same pattern constants.
- One natural sub-module: ppfifo_read_ctrl, containing the IDLE/ACTIVATE/READ/RELEASE handshake, word_idx and blk_size.
- The compare, counter and capture logic stays in the top-level module.
- Target size: roughly 200 lines of RTL total.

## Test plan
- Clean run: two blocks of 512 words carrying pattern 0..1023 → total_count=1024, error=0, strobe high for 512 consecutive cycles per block.
- Single corruption: word 300 forced to 32'hDEADBEEF → error=1, error_count=1, first_err_index=300, first_err_expected=300, first_err_actual=32'hDEADBEEF; later words still pass.
- Zero-size block: size=0 with ready high → activate high for 1 cycle, no strobe, counters unchanged.
- enable dropped at word 10 of a 64-word block → all 64 words consumed, then stays IDLE even with ready high.
- restart pulsed at word 20 of a 40-word block → 20 more words are strobed; total_count=20, and the words carrying values 20..39 report 20 mismatches against 0..19.
- Async rst asserted mid-READ → activate=0 and strobe=0 immediately, all counters 0; the next block checks from PATTERN_START.
